updown_counter_param: RTL
=========================

Name: updown_counter_param

Overview:
- Parametrised up/down counter for general counting, timing and address generation. Supersedes the fixed 8-bit up/down counter.
- Adds the following over the fixed counter:
  - programmable count range [MIN_VAL, MAX_VAL]
  - runtime step size
  - synchronous parallel load
  - selectable wrap or saturate at the range limits
  - terminal-count and boundary-crossing status outputs

Parameters:
- WIDTH, 8, counter width in bits; 2 <= WIDTH <= 32.
- MIN_VAL, 0, lower bound of the count range.
- MAX_VAL, 2**WIDTH-1, upper bound of the count range; MIN_VAL < MAX_VAL <= 2**WIDTH-1.
- STEP_W, 4, width of the step input; STEP_W <= WIDTH. The maximum step must not exceed range size R = MAX_VAL-MIN_VAL+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  count enable; 0 = hold.
- direction  in  1  1 = count up by step, 0 = count down by step.
- step  in  STEP_W  increment/decrement magnitude; 0 = hold.
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap within [MIN_VAL, MAX_VAL].
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- counter_out  out  WIDTH  registered count.
- tc  out  1  combinational terminal count.
- bound_hit  out  1  registered one-cycle pulse.

Behaviour:
- Reset:
  - rst_n=0 forces counter_out=MIN_VAL and bound_hit=0 immediately, independent of clk.
  - Release is synchronous to the next rising clk edge.
  - Reset asserted mid-count discards the in-progress value.
- Priority on each rising clk edge: load > enable > hold.
- Load:
  - counter_out <= load_val, clamped into [MIN_VAL, MAX_VAL]: below MIN_VAL gives MIN_VAL, above MAX_VAL gives MAX_VAL.
  - bound_hit <= 0.
  - Load wins over a simultaneous enable.
- Hold: enable=0 or step=0 leaves counter_out unchanged and sets bound_hit <= 0.
- Count up (enable=1, direction=1):
  - Sum computed in WIDTH+1 bits: nxt = counter_out + step.
  - nxt <= MAX_VAL: counter_out <= nxt, bound_hit <= 0.
  - nxt > MAX_VAL, sat_mode=1: counter_out <= MAX_VAL, bound_hit <= 1.
  - nxt > MAX_VAL, sat_mode=0: counter_out <= MIN_VAL + (nxt - MAX_VAL - 1), bound_hit <= 1.
- Count down (enable=1, direction=0):
  - counter_out - step < MIN_VAL is detected without underflow aliasing.
  - sat_mode=1: counter_out <= MIN_VAL.
  - sat_mode=0: counter_out <= MAX_VAL - (MIN_VAL - (counter_out - step) - 1).
  - bound_hit <= 1 in both cases.
- Saturated at the bound:
  - Once at MAX_VAL with sat_mode=1, further up-counts keep MAX_VAL and bound_hit stays 1 each cycle.
  - Same applies to MIN_VAL on down-counts.
- tc is combinational:
  - tc = 1 when direction=1 and counter_out==MAX_VAL, or direction=0 and counter_out==MIN_VAL.
  - tc does not depend on enable.
- Latency: one clock from input sample to counter_out / bound_hit update.
- Mode inputs: sat_mode and direction may change any cycle; they take effect on that cycle's edge.

Optional Feature:
- Macro: UDC_STICKY_FLAGS_EN.
- When defined, adds:
  - Outputs ovf_sticky and udf_sticky, 1 bit each.
  - Input flag_clr, 1 bit.
- ovf_sticky sets on any up-count crossing of MAX_VAL; udf_sticky sets on any down-count crossing of MIN_VAL.
- Both flags hold until flag_clr=1 or rst_n=0. Reset value is 0.
- Set wins over a simultaneous flag_clr.
- When undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: WIDTH=8 defaults, drive count to 0x37, assert rst_n=0 between edges -> counter_out=0x00 before the next edge; bound_hit=0.
- Up-wrap: MIN=10, MAX=20, load 18, step=3, sat_mode=0, up -> next edge counter_out=10, bound_hit=1; following edge 13, bound_hit=0.
- Down-saturate: MIN=10, MAX=20, load 12, step=5, sat_mode=1, down -> counter_out=10, bound_hit=1; repeats hold 10 with bound_hit=1; tc=1.
- Load clamp and priority: load=1, enable=1, load_val=25 (MAX=20) -> counter_out=20; load_val=3 -> counter_out=10; hold with enable=0 keeps 10.
- Full-range wrap: defaults, step=1, up from 0xFF -> 0x00; down from 0x00 -> 0xFF; step=0 -> no change, bound_hit=0.
- Sticky flags (UDC_STICKY_FLAGS_EN): up-wrap sets ovf_sticky=1, which persists across 5 normal counts; flag_clr=1 -> 0; simultaneous wrap + flag_clr -> stays 1.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: range [MIN_VAL, MAX_VAL], runtime step, load with clamping, wrap/saturate.
// Define UDC_STICKY_FLAGS_EN to add ovf_sticky/udf_sticky outputs and the flag_clr input.
module updown_counter_param #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MIN_VAL = '0,
    parameter logic [WIDTH-1:0] MAX_VAL = '1,
    parameter int unsigned      STEP_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              direction,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
`ifdef UDC_STICKY_FLAGS_EN
    input  logic              flag_clr,
    output logic              ovf_sticky,
    output logic              udf_sticky,
`endif
    output logic [WIDTH-1:0]  counter_out,
    output logic              tc,
    output logic              bound_hit
);

    // One spare bit so sums and differences never alias.
    typedef logic [WIDTH:0] ext_t;

    localparam ext_t MIN_X = ext_t'(MIN_VAL);
    localparam ext_t MAX_X = ext_t'(MAX_VAL);
    localparam ext_t ONE_X = ext_t'(1);

    ext_t             step_x;
    ext_t             cnt_x;
    ext_t             up_sum;
    ext_t             dn_diff;
    ext_t             lo_diff;
    ext_t             hi_diff;
    logic             counting;
    logic             up_cross;
    logic             dn_cross;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_cnt;
    logic             next_bh;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        next_cnt     = counter_out;
        next_bh      = 1'b0;
        load_clamped = load_val;

        step_x   = ext_t'(step);
        cnt_x    = ext_t'(counter_out);
        up_sum   = cnt_x + step_x;
        // Distance above MIN_VAL after the step; a set top bit means the step went below MIN_VAL.
        dn_diff  = cnt_x - MIN_X - step_x;
        up_cross = (up_sum > MAX_X);
        dn_cross = dn_diff[WIDTH];
        lo_diff  = ext_t'(load_val) - MIN_X;
        hi_diff  = MAX_X - ext_t'(load_val);
        counting = enable && (step != '0);

        if (lo_diff[WIDTH]) begin
            load_clamped = MIN_VAL;
        end else if (hi_diff[WIDTH]) begin
            load_clamped = MAX_VAL;
        end

        if (load) begin
            next_cnt = load_clamped;
        end else if (counting) begin
            if (direction) begin
                if (up_cross) begin
                    next_bh  = 1'b1;
                    next_cnt = sat_mode ? MAX_VAL : WIDTH'(MIN_X + up_sum - MAX_X - ONE_X);
                end else begin
                    next_cnt = WIDTH'(up_sum);
                end
            end else begin
                if (dn_cross) begin
                    next_bh  = 1'b1;
                    next_cnt = sat_mode ? MIN_VAL : WIDTH'(MAX_X + ONE_X + dn_diff);
                end else begin
                    next_cnt = WIDTH'(MIN_X + dn_diff);
                end
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_out <= MIN_VAL;
            bound_hit   <= 1'b0;
        end else begin
            counter_out <= next_cnt;
            bound_hit   <= next_bh;
        end
    end

    assign tc = direction ? (counter_out == MAX_VAL) : (counter_out == MIN_VAL);

`ifdef UDC_STICKY_FLAGS_EN
    logic ovf_set;
    logic udf_set;

    assign ovf_set = !load && counting &&  direction && up_cross;
    assign udf_set = !load && counting && !direction && dn_cross;

    // A new crossing takes precedence over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_sticky <= 1'b1;
            end else if (flag_clr) begin
                ovf_sticky <= 1'b0;
            end
            if (udf_set) begin
                udf_sticky <= 1'b1;
            end else if (flag_clr) begin
                udf_sticky <= 1'b0;
            end
        end
    end
`endif

endmodule
